// File: rtl/fib_lookup_walker_if.sv
// Level-search bus shared by the walker and the NUM_LEVELS level instances.
// master: the walker drives select/address/lookup word/request and reads the
//         selected level's response.
// slave : the level side (a mux in front of the level memories).
interface fib_lookup_walker_if #(
  parameter int WORD_SIZE    = 32,
  parameter int POINTER_SIZE = 1,
  parameter int NUM_LEVELS   = 4
);
  logic [$clog2(NUM_LEVELS)-1:0] lvl_sel_out;
  logic [POINTER_SIZE-1:0]       lvl_address_out;
  logic [WORD_SIZE-1:0]          lvl_lookup_cont_out;
  logic                          lvl_req_out;
  logic [POINTER_SIZE-1:0]       lvl_next_pointer_in;
  logic                          lvl_is_match_in;
  logic                          lvl_no_child_in;

  modport master (
    output lvl_sel_out, lvl_address_out, lvl_lookup_cont_out, lvl_req_out,
    input  lvl_next_pointer_in, lvl_is_match_in, lvl_no_child_in
  );
  modport slave (
    input  lvl_sel_out, lvl_address_out, lvl_lookup_cont_out, lvl_req_out,
    output lvl_next_pointer_in, lvl_is_match_in, lvl_no_child_in
  );
endinterface

// File: rtl/fib_lookup_walker.sv
// Longest-prefix-match walker for the level-tree FIB.
// Buffers one NDN name (one word per component), then for each component
// queries levels 0..NUM_LEVELS-1, following next pointers, until a match
// (advance to next component), a dead end (miss) or the name is exhausted.
// Ports:
//   clk_in, rst_n_in      clock, synchronous active-low reset
//   name_*                name word stream (valid/ready, last marks end)
//   lvl                   level bus (master side)
//   result_*              hit / match length / pointer / truncation, valid/ready
//   busy_out              walker not idle
module fib_lookup_walker #(
  parameter int WORD_SIZE       = 32,
  parameter int POINTER_SIZE    = 1,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int NUM_LEVELS      = 4,
  parameter int RESP_LATENCY    = 1
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  input  logic                                 name_valid_in,
  input  logic [WORD_SIZE-1:0]                 name_word_in,
  input  logic                                 name_last_in,
  output logic                                 name_ready_out,
  fib_lookup_walker_if.master                  lvl,
  output logic                                 result_valid_out,
  input  logic                                 result_ready_in,
  output logic                                 result_hit_out,
  output logic [$clog2(MAX_NAME_LENGTH+1)-1:0] result_match_len_out,
  output logic [POINTER_SIZE-1:0]              result_pointer_out,
  output logic                                 result_trunc_out,
  output logic                                 busy_out
);
  localparam int CW  = $clog2(MAX_NAME_LENGTH+1);
  localparam int IW  = $clog2(MAX_NAME_LENGTH);
  localparam int LVW = $clog2(NUM_LEVELS);
  localparam int LTW = $clog2(RESP_LATENCY+1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;

  logic [WORD_SIZE-1:0]    buffer [MAX_NAME_LENGTH];
  logic [CW-1:0]           count_q, comp_q, len_q;
  logic [LVW-1:0]          level_q;
  logic [POINTER_SIZE-1:0] addr_q, ptr_q;
  logic [LTW-1:0]          lat_q;
  logic                    hit_q, trunc_q;

  logic resp_due, last_comp, last_level, descend, querying;

  // Response is taken on the RESP_LATENCY-th WAIT cycle; ISSUE preloads 1.
  assign resp_due   = (state_q == WAIT) && (lat_q == LTW'(RESP_LATENCY));
  assign last_comp  = (comp_q == count_q - CW'(1));
  assign last_level = (level_q == LVW'(NUM_LEVELS-1));
  // Miss at this level but the branch continues deeper.
  assign descend    = !lvl.lvl_is_match_in && !lvl.lvl_no_child_in && !last_level;
  assign querying   = (state_q == ISSUE) || (state_q == WAIT);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (name_valid_in) state_d = name_last_in ? ISSUE : LOAD;
      LOAD:  if (name_valid_in && name_last_in) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (resp_due) begin
               if (lvl.lvl_is_match_in) state_d = last_comp ? DONE : ISSUE;
               else                     state_d = descend ? ISSUE : DONE;
             end
      DONE:  if (result_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      count_q <= '0; comp_q <= '0; len_q <= '0; level_q <= '0;
      addr_q  <= '0; ptr_q  <= '0; lat_q <= '0; hit_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (name_valid_in) begin
          buffer[0] <= name_word_in;
          count_q   <= CW'(1);
          comp_q    <= '0;
          level_q   <= '0;
          addr_q    <= '0;
        end
        LOAD: if (name_valid_in) begin
          // Components past the buffer are consumed but only flagged.
          if (count_q == CW'(MAX_NAME_LENGTH)) trunc_q <= 1'b1;
          else begin
            buffer[count_q[IW-1:0]] <= name_word_in;
            count_q <= count_q + CW'(1);
          end
        end
        ISSUE: lat_q <= LTW'(1);
        WAIT: begin
          if (!resp_due) lat_q <= lat_q + LTW'(1);
          else if (lvl.lvl_is_match_in) begin
            len_q   <= (len_q == CW'(MAX_NAME_LENGTH)) ? len_q : len_q + CW'(1);
            ptr_q   <= lvl.lvl_next_pointer_in;
            comp_q  <= comp_q + CW'(1);
            level_q <= '0;
            addr_q  <= lvl.lvl_next_pointer_in;
            if (last_comp) hit_q <= 1'b1;
          end else if (descend) begin
            level_q <= level_q + LVW'(1);
            addr_q  <= lvl.lvl_next_pointer_in;
          end
        end
        DONE: if (result_ready_in) begin
          len_q <= '0; ptr_q <= '0; trunc_q <= 1'b0; count_q <= '0; hit_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Level bus is only driven while a query is outstanding; it holds its
  // ISSUE values through WAIT because level/addr/comp change only on decision.
  assign lvl.lvl_req_out         = (state_q == ISSUE);
  assign lvl.lvl_sel_out         = querying ? level_q : '0;
  assign lvl.lvl_address_out     = querying ? addr_q  : '0;
  assign lvl.lvl_lookup_cont_out = querying ? buffer[comp_q[IW-1:0]] : '0;

  assign name_ready_out       = (state_q == IDLE) || (state_q == LOAD);
  assign busy_out             = (state_q != IDLE);
  assign result_valid_out     = (state_q == DONE);
  assign result_hit_out       = hit_q;
  assign result_match_len_out = len_q;
  assign result_pointer_out   = ptr_q;
  assign result_trunc_out     = trunc_q;
endmodule

// File: tb/tb_fib_lookup_walker.sv
module tb_fib_lookup_walker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        name_valid = 1'b0;
  logic [31:0] name_word = '0;
  logic        name_last = 1'b0;
  logic        name_ready;
  logic        res_valid, res_ready = 1'b0, res_hit, res_ptr, res_trunc, busy;
  logic [3:0]  res_len;
  int          vecs = 0, errs = 0;

  always #5 clk = ~clk;

  fib_lookup_walker_if #(.WORD_SIZE(32), .POINTER_SIZE(1), .NUM_LEVELS(4)) lvl_if ();

  fib_lookup_walker #(.WORD_SIZE(32), .POINTER_SIZE(1), .MAX_NAME_LENGTH(8),
                      .NUM_LEVELS(4), .RESP_LATENCY(1)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .name_valid_in(name_valid), .name_word_in(name_word), .name_last_in(name_last),
    .name_ready_out(name_ready), .lvl(lvl_if),
    .result_valid_out(res_valid), .result_ready_in(res_ready),
    .result_hit_out(res_hit), .result_match_len_out(res_len),
    .result_pointer_out(res_ptr), .result_trunc_out(res_trunc), .busy_out(busy)
  );

  initial begin
    lvl_if.lvl_next_pointer_in = 1'b0;
    lvl_if.lvl_is_match_in     = 1'b0;
    lvl_if.lvl_no_child_in     = 1'b0;
  end

  // Called just after a posedge; word is taken at the next posedge.
  task automatic send_word(input logic [31:0] w, input logic last);
    vecs++;
    if (name_ready !== 1'b1) begin
      errs++; $display("FAIL name_ready before word %h: got %b want 1", w, name_ready);
    end
    name_valid = 1'b1; name_word = w; name_last = last;
    @(posedge clk); #1;
    name_valid = 1'b0; name_last = 1'b0;
  endtask

  // Waits for the next query, checks what it presents, supplies the response.
  task automatic serve(input logic [1:0] sel, input logic addr, input logic [31:0] w,
                       input logic m, input logic nc, input logic np);
    int n = 0;
    do begin @(negedge clk); n++; end while (lvl_if.lvl_req_out !== 1'b1 && n < 50);
    vecs++;
    if (lvl_if.lvl_req_out !== 1'b1) begin
      errs++; $display("FAIL req_timeout: no query seen, want sel=%0d addr=%0d word=%h", sel, addr, w);
    end else if ({lvl_if.lvl_sel_out, lvl_if.lvl_address_out, lvl_if.lvl_lookup_cont_out} !== {sel, addr, w}) begin
      errs++; $display("FAIL query: got sel=%0d addr=%0d word=%h want sel=%0d addr=%0d word=%h",
                       lvl_if.lvl_sel_out, lvl_if.lvl_address_out, lvl_if.lvl_lookup_cont_out, sel, addr, w);
    end
    lvl_if.lvl_is_match_in = m; lvl_if.lvl_no_child_in = nc; lvl_if.lvl_next_pointer_in = np;
  endtask

  // Waits for the result (no further query allowed), checks fields for
  // hold+1 cycles with ready low, then handshakes and checks return to idle.
  task automatic wait_result(input logic hit, input logic [3:0] len, input logic ptr,
                             input logic trunc, input int hold);
    int n = 0;
    bit extra = 0;
    do begin
      @(negedge clk); n++;
      if (lvl_if.lvl_req_out === 1'b1) extra = 1;
    end while (res_valid !== 1'b1 && n < 200);
    vecs++;
    if (res_valid !== 1'b1 || extra) begin
      errs++; $display("FAIL result_wait: valid=%b extra_query=%0d want valid=1 extra_query=0", res_valid, extra);
    end
    for (int c = 0; c <= hold; c++) begin
      if (c > 0) @(negedge clk);
      vecs++;
      if ({res_valid, res_hit, res_len, res_ptr, res_trunc, name_ready} !== {1'b1, hit, len, ptr, trunc, 1'b0}) begin
        errs++; $display("FAIL result cyc%0d: got v=%b hit=%b len=%0d ptr=%b trunc=%b rdy=%b want v=1 hit=%b len=%0d ptr=%b trunc=%b rdy=0",
                         c, res_valid, res_hit, res_len, res_ptr, res_trunc, name_ready, hit, len, ptr, trunc);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    vecs++;
    if ({busy, res_valid, res_len, res_ptr, res_trunc, res_hit, name_ready} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errs++; $display("FAIL back_to_idle: got busy=%b v=%b len=%0d ptr=%b trunc=%b hit=%b rdy=%b want 0 0 0 0 0 0 1",
                       busy, res_valid, res_len, res_ptr, res_trunc, res_hit, name_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({res_valid, res_hit, res_len, res_ptr, res_trunc, busy} !== 9'd0) begin
      errs++; $display("FAIL reset_result: got v=%b hit=%b len=%0d ptr=%b trunc=%b busy=%b want all 0",
                       res_valid, res_hit, res_len, res_ptr, res_trunc, busy);
    end
    vecs++;
    if ({lvl_if.lvl_req_out, lvl_if.lvl_sel_out, lvl_if.lvl_address_out, lvl_if.lvl_lookup_cont_out} !== 36'd0) begin
      errs++; $display("FAIL reset_lvl: got req=%b sel=%0d addr=%b word=%h want all 0",
                       lvl_if.lvl_req_out, lvl_if.lvl_sel_out, lvl_if.lvl_address_out, lvl_if.lvl_lookup_cont_out);
    end
    vecs++;
    if (name_ready !== 1'b1) begin
      errs++; $display("FAIL reset_ready: got %b want 1", name_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_hit();
    send_word(32'h0000_00A5, 1'b1);
    serve(2'd0, 1'b0, 32'h0000_00A5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    vecs++;
    if ({lvl_if.lvl_req_out, res_valid} !== 2'b00) begin
      errs++; $display("FAIL single_wait: got req=%b valid=%b want 0 0", lvl_if.lvl_req_out, res_valid);
    end
    wait_result(1'b1, 4'd1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_descent();
    send_word(32'h0000_0010, 1'b1);
    serve(2'd0, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b1);
    serve(2'd1, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
    wait_result(1'b1, 4'd1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_deepest_level_miss();
    send_word(32'h0000_0077, 1'b1);
    serve(2'd0, 1'b0, 32'h77, 1'b0, 1'b0, 1'b1);
    serve(2'd1, 1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    serve(2'd2, 1'b0, 32'h77, 1'b0, 1'b0, 1'b1);
    serve(2'd3, 1'b1, 32'h77, 1'b0, 1'b0, 1'b1);
    wait_result(1'b0, 4'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_partial_prefix();
    send_word(32'h0000_000A, 1'b0);
    send_word(32'h0000_000B, 1'b0);
    send_word(32'h0000_000C, 1'b1);
    serve(2'd0, 1'b0, 32'hA, 1'b1, 1'b0, 1'b1);
    serve(2'd0, 1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    serve(2'd1, 1'b0, 32'hB, 1'b0, 1'b0, 1'b1);
    serve(2'd2, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
    wait_result(1'b0, 4'd1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_overflow_backpressure();
    for (int i = 1; i <= 10; i++) send_word(32'h100 + 32'(i), i == 10);
    serve(2'd0, 1'b0, 32'h101, 1'b1, 1'b0, 1'b1);
    for (int i = 2; i <= 8; i++) serve(2'd0, 1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b1);
    wait_result(1'b1, 4'd8, 1'b1, 1'b1, 5);
  endtask

  task automatic test_reset_mid_walk();
    send_word(32'h0000_0055, 1'b1);
    serve(2'd0, 1'b0, 32'h55, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if ({busy, res_valid, lvl_if.lvl_req_out, res_len, res_hit, name_ready} !== {1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1}) begin
      errs++; $display("FAIL mid_reset: got busy=%b v=%b req=%b len=%0d hit=%b rdy=%b want 0 0 0 0 0 1",
                       busy, res_valid, lvl_if.lvl_req_out, res_len, res_hit, name_ready);
    end
    rst_n = 1'b1;
    send_word(32'h0000_0066, 1'b0);
    send_word(32'h0000_0067, 1'b1);
    serve(2'd0, 1'b0, 32'h66, 1'b1, 1'b1, 1'b1);  // match wins over no_child
    serve(2'd0, 1'b1, 32'h67, 1'b0, 1'b0, 1'b0);
    serve(2'd1, 1'b0, 32'h67, 1'b1, 1'b0, 1'b1);
    wait_result(1'b1, 4'd2, 1'b1, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_hit();
    test_descent();
    test_deepest_level_miss();
    test_partial_prefix();
    test_overflow_backpressure();
    test_reset_mid_walk();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
